if_id_stage: RTL and testbench

- IF/ID pipeline stage: captures fetched pc/instruction pairs from the instruction-memory interface and presents them to decode.
- Sits directly upstream of the ID/EXE register and shares its stall, flush and memory-wait controls.
- Contains a small skid FIFO so in-flight fetch responses are not lost while decode stalls.
- A sticky flush capture ensures a branch or interrupt redirect raised during a memory wait is never dropped.

---
 rtl/if_id_stage_pkg.sv | 13 +
 rtl/if_id_skid_fifo.sv | 57 +++++
 rtl/if_id_stage.sv | 148 ++++++++++++++
 tb/tb_if_id_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
// Shared CPU definitions for the fetch/decode boundary: datapath width,
// the bubble instruction encoding and the fetched pc/instruction packet.
package if_id_stage_pkg;

    localparam int unsigned CPU_XLEN = 32;
    localparam logic [CPU_XLEN-1:0] CPU_BUBBLE_INST = 32'd0;

    typedef struct packed {
        logic [CPU_XLEN-1:0] pc;
        logic [CPU_XLEN-1:0] inst;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_skid_fifo.sv
// Circular skid buffer holding fetch packets that arrive while decode is stalled.
// Flush clears it in one cycle; the caller never pops when empty or pushes when full.
module if_id_skid_fifo
    import if_id_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  fetch_pkt_t    wdata_i,
    output fetch_pkt_t    rdata_o,
    output logic [CW-1:0] count_o
);

    fetch_pkt_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: {CPU_XLEN{1'b0}}, inst: CPU_BUBBLE_INST};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else if (flush_i) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1'b1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1'b1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1'b1);
                2'b01:   count_q <= count_q - CW'(1'b1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with skid FIFO and sticky flush capture across memory waits.
// Optional macro IF_ID_PERF_CNT_EN adds bubble_cnt/flush_cnt performance counters.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int unsigned       XLEN        = CPU_XLEN,
    parameter int unsigned       DEPTH       = 2,
    parameter logic [XLEN-1:0]   BUBBLE_INST = CPU_BUBBLE_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic [XLEN-1:0] pc_F,
    input  logic [XLEN-1:0] inst_F,
    input  logic            stall,
    input  logic            stall_IF,
    input  logic            next_pc_sel,
    input  logic            wfi_signal,
    input  logic            intr_ex,
    input  logic            intr_end_ex,
`ifdef IF_ID_PERF_CNT_EN
    output logic [31:0]     bubble_cnt,
    output logic [31:0]     flush_cnt,
`endif
    output logic [XLEN-1:0] pc_D,
    output logic [XLEN-1:0] inst_RegD,
    output logic            valid_D
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic            flush_req_s;
    logic            flush_now_s;
    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            advance_s;
    logic            pop_s;
    logic            fifo_push_s;
    logic [CW-1:0]   count_s;
    fetch_pkt_t      head_s;
    fetch_pkt_t      in_pkt_s;

    logic            flush_pending_q, flush_pending_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            valid_q, valid_d;

    assign flush_req_s = next_pc_sel | wfi_signal | intr_ex | intr_end_ex;
    assign flush_now_s = !stall_IF & (flush_req_s | flush_pending_q);
    assign full_s      = (count_s == CW'(DEPTH));
    assign empty_s     = (count_s == {CW{1'b0}});
    // Full blocks acceptance even when popping, keeping stall off the fetch_ready path.
    assign fetch_ready = !stall_IF & !flush_now_s & !full_s;
    assign push_s      = fetch_valid & fetch_ready;
    assign advance_s   = !stall_IF & !flush_now_s & !stall;
    assign pop_s       = advance_s & !empty_s;
    assign fifo_push_s = push_s & !(advance_s & empty_s);
    assign in_pkt_s    = '{pc: pc_F, inst: inst_F};

    if_id_skid_fifo #(
        .DEPTH (DEPTH)
    ) u_skid_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_now_s),
        .push_i  (fifo_push_s),
        .pop_i   (pop_s),
        .wdata_i (in_pkt_s),
        .rdata_o (head_s),
        .count_o (count_s)
    );

    // Next decode register contents and sticky flush capture.
    always_comb begin
        pc_d            = pc_q;
        inst_d          = inst_q;
        valid_d         = valid_q;
        flush_pending_d = flush_pending_q;
        if (stall_IF) begin
            flush_pending_d = flush_pending_q | flush_req_s;
        end else if (flush_now_s) begin
            pc_d            = {XLEN{1'b0}};
            inst_d          = BUBBLE_INST;
            valid_d         = 1'b0;
            flush_pending_d = 1'b0;
        end else if (stall) begin
            pc_d    = pc_q;
            inst_d  = inst_q;
            valid_d = valid_q;
        end else if (!empty_s) begin
            pc_d    = head_s.pc;
            inst_d  = head_s.inst;
            valid_d = 1'b1;
        end else if (push_s) begin
            pc_d    = pc_F;
            inst_d  = inst_F;
            valid_d = 1'b1;
        end else begin
            pc_d    = {XLEN{1'b0}};
            inst_d  = BUBBLE_INST;
            valid_d = 1'b0;
        end
    end

    // Decode register and flush_pending state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q            <= {XLEN{1'b0}};
            inst_q          <= BUBBLE_INST;
            valid_q         <= 1'b0;
            flush_pending_q <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            inst_q          <= inst_d;
            valid_q         <= valid_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    assign pc_D      = pc_q;
    assign inst_RegD = inst_q;
    assign valid_D   = valid_q;

`ifdef IF_ID_PERF_CNT_EN
    logic        bubble_load_s;
    logic [31:0] bubble_cnt_q;
    logic [31:0] flush_cnt_q;

    assign bubble_load_s = advance_s & empty_s & !push_s;

    // Free-running wrap-around event counters; both are idle while stall_IF holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt_q <= 32'd0;
            flush_cnt_q  <= 32'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_q + {31'd0, bubble_load_s};
            flush_cnt_q  <= flush_cnt_q + {31'd0, flush_now_s};
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed, table-driven bench for if_id_stage plus hand sequences for reset and counters.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] pc_F;
    logic [31:0] inst_F;
    logic        stall;
    logic        stall_IF;
    logic        next_pc_sel;
    logic        wfi_signal;
    logic        intr_ex;
    logic        intr_end_ex;
    logic [31:0] pc_D;
    logic [31:0] inst_RegD;
    logic        valid_D;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    if_id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .pc_F        (pc_F),
        .inst_F      (inst_F),
        .stall       (stall),
        .stall_IF    (stall_IF),
        .next_pc_sel (next_pc_sel),
        .wfi_signal  (wfi_signal),
        .intr_ex     (intr_ex),
        .intr_end_ex (intr_end_ex),
`ifdef IF_ID_PERF_CNT_EN
        .bubble_cnt  (bubble_cnt),
        .flush_cnt   (flush_cnt),
`endif
        .pc_D        (pc_D),
        .inst_RegD   (inst_RegD),
        .valid_D     (valid_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        st;
        logic        sif;
        logic [3:0]  fl;     // {next_pc_sel, wfi_signal, intr_ex, intr_end_ex}
        logic        e_rdy;  // fetch_ready before the edge
        logic [31:0] e_pc;   // D after the edge
        logic [31:0] e_inst;
        logic        e_v;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic fv, logic [31:0] pc, logic [31:0] inst, logic st,
                                logic sif, logic [3:0] fl, logic e_rdy,
                                logic [31:0] e_pc, logic [31:0] e_inst, logic e_v);
        vec_t v;
        v.fv = fv; v.pc = pc; v.inst = inst; v.st = st; v.sif = sif; v.fl = fl;
        v.e_rdy = e_rdy; v.e_pc = e_pc; v.e_inst = e_inst; v.e_v = e_v;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                         input logic st, input logic sif, input logic [3:0] fl);
        fetch_valid = fv; pc_F = pc; inst_F = inst; stall = st; stall_IF = sif;
        {next_pc_sel, wfi_signal, intr_ex, intr_end_ex} = fl;
    endtask

    task automatic chk_d(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                         input logic e_v);
        chk({tag, ".pc_D"}, pc_D, e_pc);
        chk({tag, ".inst_RegD"}, inst_RegD, e_inst);
        chk({tag, ".valid_D"}, {31'd0, valid_D}, {31'd0, e_v});
    endtask

    initial begin
        // Flush codes
        logic [3:0] NO, BR, WF, IE, IR;
        NO = 4'b0000; BR = 4'b1000; WF = 4'b0100; IE = 4'b0010; IR = 4'b0001;

        // idle / bypass
        vq.push_back(mk(1'b0, 32'h0,   32'h0,        1'b0, 1'b0, NO, 1'b1, 32'h0,   32'h0,        1'b0));
        vq.push_back(mk(1'b1, 32'h100, 32'h00500093, 1'b0, 1'b0, NO, 1'b1, 32'h100, 32'h00500093, 1'b1));
        // decode stall fills the FIFO, then drains in order
        vq.push_back(mk(1'b1, 32'h104, 32'h00A00113, 1'b1, 1'b0, NO, 1'b1, 32'h100, 32'h00500093, 1'b1));
        vq.push_back(mk(1'b1, 32'h108, 32'h00B00193, 1'b1, 1'b0, NO, 1'b1, 32'h100, 32'h00500093, 1'b1));
        vq.push_back(mk(1'b1, 32'h10C, 32'h00C00213, 1'b1, 1'b0, NO, 1'b0, 32'h100, 32'h00500093, 1'b1));
        vq.push_back(mk(1'b0, 32'h0,   32'h0,        1'b0, 1'b0, NO, 1'b0, 32'h104, 32'h00A00113, 1'b1));
        vq.push_back(mk(1'b0, 32'h0,   32'h0,        1'b0, 1'b0, NO, 1'b1, 32'h108, 32'h00B00193, 1'b1));
        vq.push_back(mk(1'b0, 32'h0,   32'h0,        1'b0, 1'b0, NO, 1'b1, 32'h0,   32'h0,        1'b0));
        // branch flush with full FIFO drops the concurrent response
        vq.push_back(mk(1'b1, 32'h200, 32'h11111111, 1'b1, 1'b0, NO, 1'b1, 32'h0,   32'h0,        1'b0));
        vq.push_back(mk(1'b1, 32'h204, 32'h22222222, 1'b1, 1'b0, NO, 1'b1, 32'h0,   32'h0,        1'b0));
        vq.push_back(mk(1'b1, 32'h10C, 32'h00C00213, 1'b1, 1'b0, BR, 1'b0, 32'h0,   32'h0,        1'b0));
        vq.push_back(mk(1'b1, 32'h300, 32'h33333333, 1'b0, 1'b0, NO, 1'b1, 32'h300, 32'h33333333, 1'b1));
        // interrupt raised during memory wait is remembered
        vq.push_back(mk(1'b1, 32'h304, 32'h44444444, 1'b0, 1'b1, IE, 1'b0, 32'h300, 32'h33333333, 1'b1));
        vq.push_back(mk(1'b1, 32'h304, 32'h44444444, 1'b0, 1'b1, NO, 1'b0, 32'h300, 32'h33333333, 1'b1));
        vq.push_back(mk(1'b1, 32'h304, 32'h44444444, 1'b0, 1'b1, NO, 1'b0, 32'h300, 32'h33333333, 1'b1));
        vq.push_back(mk(1'b1, 32'h304, 32'h44444444, 1'b0, 1'b1, NO, 1'b0, 32'h300, 32'h33333333, 1'b1));
        vq.push_back(mk(1'b1, 32'h304, 32'h44444444, 1'b0, 1'b0, NO, 1'b0, 32'h0,   32'h0,        1'b0));
        vq.push_back(mk(1'b1, 32'h304, 32'h44444444, 1'b0, 1'b0, NO, 1'b1, 32'h304, 32'h44444444, 1'b1));
        // other flush sources
        vq.push_back(mk(1'b0, 32'h0,   32'h0,        1'b0, 1'b0, WF, 1'b0, 32'h0,   32'h0,        1'b0));
        vq.push_back(mk(1'b1, 32'h400, 32'h55555555, 1'b0, 1'b0, NO, 1'b1, 32'h400, 32'h55555555, 1'b1));
        vq.push_back(mk(1'b0, 32'h0,   32'h0,        1'b0, 1'b0, IR, 1'b0, 32'h0,   32'h0,        1'b0));
        // simultaneous pop and push keep order
        vq.push_back(mk(1'b1, 32'h500, 32'h66666666, 1'b1, 1'b0, NO, 1'b1, 32'h0,   32'h0,        1'b0));
        vq.push_back(mk(1'b1, 32'h504, 32'h77777777, 1'b0, 1'b0, NO, 1'b1, 32'h500, 32'h66666666, 1'b1));
        vq.push_back(mk(1'b0, 32'h0,   32'h0,        1'b0, 1'b0, NO, 1'b1, 32'h504, 32'h77777777, 1'b1));
        vq.push_back(mk(1'b0, 32'h0,   32'h0,        1'b0, 1'b0, NO, 1'b1, 32'h0,   32'h0,        1'b0));

        // Reset state
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, NO);
        #1;
        chk_d("reset", 32'h0, 32'h0, 1'b0);
        chk("reset.fetch_ready", {31'd0, fetch_ready}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].fv, vq[i].pc, vq[i].inst, vq[i].st, vq[i].sif, vq[i].fl);
            #1;
            chk($sformatf("v%0d.fetch_ready", i), {31'd0, fetch_ready}, {31'd0, vq[i].e_rdy});
            @(posedge clk);
            #1;
            chk_d($sformatf("v%0d", i), vq[i].e_pc, vq[i].e_inst, vq[i].e_v);
        end

        // Asynchronous reset mid-stream with a full FIFO and valid D
        drive(1'b1, 32'h5F0, 32'h88888888, 1'b0, 1'b0, NO);
        @(posedge clk); #1;
        drive(1'b1, 32'h600, 32'h99999999, 1'b1, 1'b0, NO);
        @(posedge clk); #1;
        drive(1'b1, 32'h604, 32'hAAAAAAAA, 1'b1, 1'b0, NO);
        @(posedge clk); #1;
        chk_d("pre_rst", 32'h5F0, 32'h88888888, 1'b1);
        chk("pre_rst.fetch_ready", {31'd0, fetch_ready}, 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, NO);
        #2 rst = 1'b0;
        #1;
        chk_d("async_rst", 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("post_rst.fetch_ready", {31'd0, fetch_ready}, 32'd1);
        drive(1'b1, 32'h700, 32'hBBBBBBBB, 1'b0, 1'b0, NO);
        @(posedge clk); #1;
        chk_d("post_rst_bypass", 32'h700, 32'hBBBBBBBB, 1'b1);

`ifdef IF_ID_PERF_CNT_EN
        // Two flush cycles then five bubble-advance cycles from a fresh reset
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, BR);
        rst = 1'b0;
        #2;
        chk("perf_rst.bubble_cnt", bubble_cnt, 32'd0);
        chk("perf_rst.flush_cnt", flush_cnt, 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, NO);
        repeat (5) @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, BR);
        repeat (3) @(posedge clk);
        #1;
        chk("perf.flush_cnt", flush_cnt, 32'd2);
        chk("perf.bubble_cnt", bubble_cnt, 32'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
